// File: rtl/ramb4_arb_pkg.sv
// Shared types and defaults for the RAMB4 wide-port arbiter.
package ramb4_arb_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 16;
  localparam logic [15:0] CLEAR_VALUE_DEFAULT = 16'h0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

endpackage

// File: rtl/ramb4_s16_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any_valid
);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any_valid && eligible[cand]) begin
        any_valid    = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ramb4_s16_port_arbiter.sv
// Round-robin arbiter sharing the 16-bit port of a RAMB4_S2_S16 between NREQ requesters.
// Optional power-up clear sequencer enabled by defining RAMB4_ARB_CLEAR_EN.
module ramb4_s16_port_arbiter
  import ramb4_arb_pkg::*;
#(
  parameter int            NREQ        = 2,
  parameter int            AW          = AW_DEFAULT,
  parameter int            DW          = DW_DEFAULT,
  parameter logic [DW-1:0] CLEAR_VALUE = DW'(CLEAR_VALUE_DEFAULT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  WE_REQ,
  input  logic [NREQ*AW-1:0] ADDR_REQ,
  input  logic [NREQ*DW-1:0] DIN_REQ,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  DVALID,
  output logic [DW-1:0]    DOUT,
  output logic             BUSY,
  output logic             RAM_EN,
  output logic             RAM_WE,
  output logic [AW-1:0]    RAM_ADDR,
  output logic [DW-1:0]    RAM_DI,
  input  logic [DW-1:0]    RAM_DO
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] dvalid_q, dvalid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_di_q, ram_di_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic            any_valid;
  logic            busy;

`ifdef RAMB4_ARB_CLEAR_EN
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  assign busy = (state_q == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  // A requester in its GNT cycle is not eligible, so it may drop REQ late.
  assign eligible = REQ & ~gnt_q & {NREQ{~busy}};

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .onehot    (win_onehot),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    gnt_d      = '0;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    ptr_d      = ptr_q;
    // A read command issued last cycle is executed by the RAM at this edge.
    dvalid_d   = (ram_en_q && !ram_we_q) ? gnt_q : '0;
`ifdef RAMB4_ARB_CLEAR_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == ST_CLEAR) begin
      ram_en_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = cnt_q;
      ram_di_d   = CLEAR_VALUE;
      cnt_d      = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_ARB;
    end else
`endif
    if (any_valid) begin
      gnt_d    = win_onehot;
      ram_en_d = 1'b1;
      ptr_d    = win_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (win_onehot[i]) begin
          ram_we_d   = WE_REQ[i];
          ram_addr_d = ADDR_REQ[i*AW +: AW];
          ram_di_d   = DIN_REQ[i*DW +: DW];
        end
      end
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_q      <= '0;
      dvalid_q   <= '0;
      ptr_q      <= IW'(NREQ - 1);
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
`ifdef RAMB4_ARB_CLEAR_EN
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
`endif
    end else begin
      gnt_q      <= gnt_d;
      dvalid_q   <= dvalid_d;
      ptr_q      <= ptr_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
`ifdef RAMB4_ARB_CLEAR_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign GNT      = gnt_q;
  assign DVALID   = dvalid_q;
  assign DOUT     = RAM_DO;
  assign BUSY     = busy;
  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = ram_we_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;

endmodule

// File: doc/ramb4_s16_port_arbiter.md
Name: ramb4_s16_port_arbiter

Overview:
- Shares the 16-bit wide port (256 x 16) of a RAMB4_S2_S16-class block RAM between NREQ requesters using round-robin arbitration.
- Registers one RAM command per cycle and returns read data with a per-requester valid strobe.
- The 2-bit narrow port is untouched and stays owned by its single client.
- Sits between the requesting engines (PicoBlaze I/O logic, DMA-style fill) and the RAM primitive's B-side pins.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 8, wide-port address width (256 words).
- DW, 16, wide-port data width.
- CLEAR_VALUE, 16'h0000, word written by the optional clear sequencer.

Ports:
- CLK  input  1  single clock; also drives the RAM wide-port clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NREQ  per-requester request; held high with operands stable until GNT is seen.
- WE_REQ  input  NREQ  per-requester write qualifier (1 = write, 0 = read).
- ADDR_REQ  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- DIN_REQ  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- GNT  output  NREQ  one-hot, one-cycle pulse: request accepted at the preceding edge.
- DVALID  output  NREQ  one-hot, one-cycle pulse: DOUT holds read data for that requester.
- DOUT  output  DW  read data; pass-through of RAM_DO.
- BUSY  output  1  high while the clear sequence runs; no grants are issued.
- RAM_EN  output  1  wide-port enable, registered.
- RAM_WE  output  1  wide-port write enable, registered.
- RAM_ADDR  output  AW  wide-port address, registered.
- RAM_DI  output  DW  wide-port write data, registered.
- RAM_DO  input  DW  wide-port read data from the RAM.

Behaviour:
- Reset values: GNT=0, DVALID=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0. Round-robin pointer = NREQ-1, so requester 0 wins first. BUSY=0 when the macro is absent, 1 when present. The RAM's own RST pin is tied low by the integrator.
- Eligibility: requester i is eligible at an edge if REQ[i]=1 and GNT[i]=0 in the current cycle. A requester may therefore drop REQ in its GNT cycle without being granted twice.
- Arbitration: at each edge with BUSY=0, pick the first eligible index searching from pointer+1 upward, wrapping modulo NREQ. Then, registered together:
  - GNT[winner]=1
  - RAM_EN=1, RAM_WE=WE_REQ[winner]
  - RAM_ADDR, RAM_DI taken from the winner's slices
  - pointer=winner
  - If nothing is eligible: GNT=0, RAM_EN=0, RAM_WE=0, pointer unchanged.
- Latency:
  - REQ high before edge E1 -> GNT and RAM command valid after E1.
  - RAM executes at E2; for a read, DVALID[winner]=1 after E2 with DOUT=RAM_DO.
  - Writes produce no DVALID.
- Throughput: one access per cycle across all requesters; a single requester alone gets at most one grant every 2 cycles.
- Read-after-write to the same address in consecutive grants returns the new data (RAM is sequential at the port).
- Operand stability: REQ, WE_REQ, ADDR_REQ and DIN_REQ are sampled only at the granting edge. Changing them before GNT is legal; the latest values win.
- RST mid-operation: an in-flight read's DVALID is suppressed (cleared at the reset edge). Pointer and outputs return to reset values.

Optional Feature:
- Macro RAMB4_ARB_CLEAR_EN.
- Defined: adds a two-state FSM, CLEAR -> ARB. RST enters CLEAR with counter=0 and BUSY=1. Each cycle it issues RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, RAM_DI=CLEAR_VALUE, then increments the counter. After address 2^AW-1 is issued, the FSM moves to ARB and BUSY falls; arbitration starts at the next edge. REQ is ignored and GNT stays 0 throughout CLEAR. RST during CLEAR restarts at address 0.
- Undefined: no FSM or counter; BUSY is constant 0; arbitration starts at the first edge after RST deasserts.

Decomposition:
- Package ramb4_arb_pkg:
  - AW/DW defaults
  - state enum {ST_CLEAR, ST_ARB}
  - CLEAR_VALUE default
- One sub-module, rr_pick: combinational round-robin picker. Inputs: eligible vector, pointer. Outputs: one-hot winner, winner index, any_valid.
- The top level holds the registers, the FSM and the operand muxing.

Test Plan:
- Reset then single read: REQ[0]=1, WE=0, ADDR=8'h05 with RAM preloaded 16'hBEEF -> GNT[0] one cycle later, then DVALID[0]=1 and DOUT=16'hBEEF the cycle after.
- Write/read-back: requester 1 writes 16'h1234 to 8'hFF, then reads 8'hFF -> DVALID[1] with DOUT=16'h1234; no DVALID on the write.
- Contention: REQ=2'b11 held continuously for 6 cycles -> GNT sequence 01,10,01,10,01,10; one RAM_EN per cycle.
- Single requester holding REQ high -> GNT pulses every other cycle, never two consecutive cycles.
- Reset mid-read: RST asserted the cycle after GNT[0] -> DVALID stays 0; after release, requester 0 wins first again.
- RAMB4_ARB_CLEAR_EN defined: after RST, BUSY=1 for exactly 256 cycles and REQ=2'b01 during that time gets no GNT. Afterwards, reads of 8'h00 and 8'hFF return 16'h0000 and the first GNT appears the cycle after BUSY falls.
